if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and fetches from instruction memory over a ready handshake.
- Selects the next PC from decode's pcsource/bpc/jpc/register target.
- Supplies pc4 and inst to decode; honours load-use stall and flushes on taken redirects.

---
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// A one-entry skid buffer holds a word that returns while decode is stalled.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc4_id,
    output logic [31:0] inst_id,
    output logic        valid_id
);

    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [31:0] skid_q;
    logic [31:0] skid_pc4_q;

    logic [31:0] pc_plus4;
    logic [31:0] target_d;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = valid_q & (pcsource != 2'b00) & ~stall;

    always_comb begin
        target_d = bpc;
        case (pcsource)
            2'b10:   target_d = ra;
            2'b11:   target_d = jpc;
            default: target_d = bpc;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            skid_q     <= NOP_INST;
            skid_pc4_q <= 32'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect) begin
                        // Taken redirect squashes whatever memory returned this cycle.
                        pc_q    <= target_d;
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end else if (stall) begin
                        if (imem_ready) begin
                            skid_q     <= imem_rdata;
                            skid_pc4_q <= pc_plus4;
                            state_q    <= S_HOLD;
                        end
                    end else if (imem_ready) begin
                        inst_q  <= imem_rdata;
                        pc4_q   <= pc_plus4;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4;
                    end else begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state_q <= S_REQ;
                        if (redirect) begin
                            pc_q    <= target_d;
                            inst_q  <= NOP_INST;
                            valid_q <= 1'b0;
                        end else begin
                            inst_q  <= skid_q;
                            pc4_q   <= skid_pc4_q;
                            valid_q <= 1'b1;
                            pc_q    <= skid_pc4_q;
                        end
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign pc4_id    = pc4_q;
    assign inst_id   = inst_q;
    assign valid_id  = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage; memory returns 32'hA000_0000 | addr.
module tb_if_stage;

    logic        clk, clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        stall, imem_ready;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_rdata, pc4_id, inst_id;
    logic [31:0] imem_addr2, imem_rdata2, pc4_id2, inst_id2;
    logic        valid_id, valid_id2;

    int pass_cnt = 0;
    int total    = 0;

    if_stage dut (
        .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .ra(ra),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .pc4_id(pc4_id), .inst_id(inst_id), .valid_id(valid_id)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .ra(ra),
        .stall(stall), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_ready(imem_ready),
        .pc4_id(pc4_id2), .inst_id(inst_id2), .valid_id(valid_id2)
    );

    assign imem_rdata  = 32'hA000_0000 | imem_addr;
    assign imem_rdata2 = 32'hA000_0000 | imem_addr2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ps;
        logic        st;
        logic        rdy;
        logic [31:0] addr;
        logic        req;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        pc4_chk;
        logic        vld;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic [1:0] ps, logic st, logic rdy, logic [31:0] addr,
                                logic req, logic [31:0] inst, logic [31:0] pc4,
                                logic pc4_chk, logic vld);
        vec_t v;
        v.ps = ps; v.st = st; v.rdy = rdy; v.addr = addr; v.req = req;
        v.inst = inst; v.pc4 = pc4; v.pc4_chk = pc4_chk; v.vld = vld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        //                ps    st rdy addr          req inst          pc4          chk vld
        vecs[0]  = mk(2'b00, 0, 1, 32'h04, 1, 32'hA000_0000, 32'h04, 1, 1);
        vecs[1]  = mk(2'b00, 0, 1, 32'h08, 1, 32'hA000_0004, 32'h08, 1, 1);
        vecs[2]  = mk(2'b00, 0, 0, 32'h08, 1, 32'h0,         32'h08, 0, 0);
        vecs[3]  = mk(2'b00, 0, 0, 32'h08, 1, 32'h0,         32'h08, 0, 0);
        vecs[4]  = mk(2'b00, 0, 0, 32'h08, 1, 32'h0,         32'h08, 0, 0);
        vecs[5]  = mk(2'b00, 0, 1, 32'h0C, 1, 32'hA000_0008, 32'h0C, 1, 1);
        vecs[6]  = mk(2'b00, 0, 1, 32'h10, 1, 32'hA000_000C, 32'h10, 1, 1);
        vecs[7]  = mk(2'b00, 1, 1, 32'h10, 0, 32'hA000_000C, 32'h10, 1, 1);
        vecs[8]  = mk(2'b00, 1, 1, 32'h10, 0, 32'hA000_000C, 32'h10, 1, 1);
        vecs[9]  = mk(2'b00, 0, 1, 32'h14, 1, 32'hA000_0010, 32'h14, 1, 1);
        vecs[10] = mk(2'b00, 0, 1, 32'h18, 1, 32'hA000_0014, 32'h18, 1, 1);
        vecs[11] = mk(2'b01, 0, 1, 32'h40, 1, 32'h0,         32'h0,  0, 0);
        vecs[12] = mk(2'b00, 0, 1, 32'h44, 1, 32'hA000_0040, 32'h44, 1, 1);
        vecs[13] = mk(2'b10, 0, 1, 32'h80, 1, 32'h0,         32'h0,  0, 0);
        vecs[14] = mk(2'b10, 0, 1, 32'h84, 1, 32'hA000_0080, 32'h84, 1, 1);
        vecs[15] = mk(2'b11, 0, 1, 32'hC0, 1, 32'h0,         32'h0,  0, 0);
        vecs[16] = mk(2'b00, 0, 1, 32'hC4, 1, 32'hA000_00C0, 32'hC4, 1, 1);
        vecs[17] = mk(2'b11, 1, 1, 32'hC4, 0, 32'hA000_00C0, 32'hC4, 1, 1);
        vecs[18] = mk(2'b11, 1, 1, 32'hC4, 0, 32'hA000_00C0, 32'hC4, 1, 1);
        vecs[19] = mk(2'b11, 0, 1, 32'hC0, 1, 32'h0,         32'h0,  0, 0);
        vecs[20] = mk(2'b00, 0, 1, 32'hC4, 1, 32'hA000_00C0, 32'hC4, 1, 1);
        vecs[21] = mk(2'b00, 1, 0, 32'hC4, 1, 32'hA000_00C0, 32'hC4, 1, 1);
        vecs[22] = mk(2'b00, 0, 1, 32'hC8, 1, 32'hA000_00C4, 32'hC8, 1, 1);

        bpc = 32'h40; ra = 32'h80; jpc = 32'hC0;
        pcsource = 2'b00; stall = 1'b0; imem_ready = 1'b0;
        clrn = 1'b1;
        #1 clrn = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_addr",  imem_addr,  32'h0);
        chk("rst_req",   {31'd0, imem_req}, 32'd1);
        chk("rst_inst",  inst_id,    32'h0);
        chk("rst_pc4",   pc4_id,     32'h0);
        chk("rst_valid", {31'd0, valid_id}, 32'd0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
        clrn = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            pcsource   = vecs[i].ps;
            stall      = vecs[i].st;
            imem_ready = vecs[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].req});
            chk($sformatf("v%0d_inst", i),  inst_id, vecs[i].inst);
            chk($sformatf("v%0d_valid", i), {31'd0, valid_id}, {31'd0, vecs[i].vld});
            if (vecs[i].pc4_chk) chk($sformatf("v%0d_pc4", i), pc4_id, vecs[i].pc4);
            if (i == 0) begin
                chk("wrap_pc4",  pc4_id2,    32'h0);
                chk("wrap_addr", imem_addr2, 32'h0);
                chk("wrap_inst", inst_id2,   32'hFFFF_FFFC);
            end
        end

        // Reset while a skid word is held: everything restarts from RESET_PC.
        @(negedge clk);
        stall = 1'b1; imem_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_addr",  imem_addr, 32'h0);
        chk("mid_rst_req",   {31'd0, imem_req}, 32'd1);
        chk("mid_rst_inst",  inst_id,   32'h0);
        chk("mid_rst_pc4",   pc4_id,    32'h0);
        chk("mid_rst_valid", {31'd0, valid_id}, 32'd0);
        @(posedge clk); #2;
        clrn = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_addr",  imem_addr, 32'h04);
        chk("post_rst_inst",  inst_id,   32'hA000_0000);
        chk("post_rst_pc4",   pc4_id,    32'h04);
        chk("post_rst_valid", {31'd0, valid_id}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
